// File: rtl/mips_cpu_mem_pkg.sv
// Shared definitions for the MIPS memory-stage bus master: op encodings,
// FSM states, byte-lane constants and request decode helpers.
package mips_cpu_mem_pkg;

  // Load encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LBU = 3'b001;
  localparam logic [2:0] LH  = 3'b010;
  localparam logic [2:0] LHU = 3'b011;
  localparam logic [2:0] LW  = 3'b101;
  localparam logic [2:0] LWL = 3'b110;
  localparam logic [2:0] LWR = 3'b111;

  // Store encodings share codes with the matching-width loads
  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b010;
  localparam logic [2:0] SW = 3'b101;

  localparam logic [3:0] BE_ALL = 4'b1111;
  localparam logic [3:0] BE_LO  = 4'b0011;
  localparam logic [3:0] BE_HI  = 4'b1100;
  localparam logic [3:0] BE_B0  = 4'b0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Fold unknown encodings onto LW/SW so downstream logic sees legal ops only.
  function automatic logic [2:0] norm_op(input logic is_store, input logic [2:0] op);
    if (is_store) return (op == SB || op == SH) ? op : SW;
    else          return (op == 3'b100) ? LW : op;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] o);
    case (op)
      LH, LHU: return o[0];
      LW:      return o != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] force_align(input logic [2:0] op, input logic [1:0] o);
    case (op)
      LH, LHU: return {o[1], 1'b0};
      LW:      return 2'b00;
      default: return o;
    endcase
  endfunction

endpackage

// File: rtl/mips_cpu_load_align.sv
// Combinational lane alignment and LWL/LWR merge of a read word with old rt.
module mips_cpu_load_align
  import mips_cpu_mem_pkg::*;
(
  input  logic [31:0] m,
  input  logic [31:0] rt,
  input  logic [1:0]  o,
  input  logic [2:0]  op,
  output logic [31:0] data,
  output logic [2:0]  ctrl
);

  logic [4:0] sh_o;
  logic [5:0] lwl_mask_sh;

  assign sh_o        = {o, 3'b000};
  // Shift of 32 (o=3) empties the rt mask entirely.
  assign lwl_mask_sh = {({1'b0, o} + 3'd1), 3'b000};

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    data = m;
    ctrl = LW;
    case (op)
      LB, LBU, LH, LHU: begin
        data = m >> sh_o;
        ctrl = op;
      end
      LWL: data = (m << (5'd24 - sh_o)) | (rt & (32'hFFFF_FFFF >> lwl_mask_sh));
      LWR: data = (m >> sh_o) | (rt & ~(32'hFFFF_FFFF >> sh_o));
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_cpu_mem_access.sv
// Memory-stage bus master: runs one load/store per transaction on an
// Avalon-style data bus and returns aligned load words to the load selector.
module mips_cpu_mem_access
  import mips_cpu_mem_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [2:0]        rsp_ctrl,
  output logic              addr_err,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata
);

  state_e      state;
  logic [2:0]  op_q;
  logic        is_store_q;
  logic [1:0]  off_q;
  logic [31:0] rt_q;

  logic [2:0]  op_n;
  logic        bad_n;
  logic [1:0]  off_n;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [31:0] align_data;
  logic [2:0]  align_ctrl;

  assign req_ready = (state == IDLE);

  // Request decode, evaluated against the live request in IDLE.
  assign op_n  = norm_op(req_is_store, req_op);
  assign bad_n = is_misaligned(op_n, req_addr[1:0]);
  assign off_n = ERR_ON_MISALIGN ? req_addr[1:0] : force_align(op_n, req_addr[1:0]);

  always_comb begin
    be_n = BE_ALL;
    wd_n = req_wdata;
    if (req_is_store) begin
      case (op_n)
        SB: begin
          be_n = BE_B0 << off_n;
          wd_n = {4{req_wdata[7:0]}};
        end
        SH: begin
          be_n = off_n[1] ? BE_HI : BE_LO;
          wd_n = {2{req_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  mips_cpu_load_align u_align (
    .m    (avm_readdata),
    .rt   (rt_q),
    .o    (off_q),
    .op   (op_q),
    .data (align_data),
    .ctrl (align_ctrl)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      op_q           <= '0;
      is_store_q     <= 1'b0;
      off_q          <= '0;
      rt_q           <= '0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_ctrl       <= '0;
      addr_err       <= 1'b0;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_byteenable <= '0;
      avm_writedata  <= '0;
    end else begin
      addr_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q       <= op_n;
            is_store_q <= req_is_store;
            off_q      <= off_n;
            rt_q       <= req_wdata;
            if (ERR_ON_MISALIGN && bad_n) begin
              addr_err <= 1'b1;
            end else begin
              state          <= BUS;
              avm_read       <= !req_is_store;
              avm_write      <= req_is_store;
              avm_address    <= {req_addr[ADDR_W-1:2], 2'b00};
              avm_byteenable <= be_n;
              avm_writedata  <= wd_n;
            end
          end
        end
        BUS: begin
          if (!avm_waitrequest) begin
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
            if (is_store_q) begin
              state <= IDLE;
            end else begin
              rsp_data  <= align_data;
              rsp_ctrl  <= align_ctrl;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_mem_access.sv
// Directed bench for mips_cpu_mem_access: vector table of single transactions
// plus hand-written sequences for wait states, back-pressure, misalignment, reset.
module tb_mips_cpu_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_ctrl;
  logic        addr_err;
  logic [31:0] avm_address;
  logic        avm_read, avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_cpu_mem_access dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_is_store    (req_is_store),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .rsp_ctrl        (rsp_ctrl),
    .addr_err        (addr_err),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_byteenable  (avm_byteenable),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata)
  );

  typedef struct {
    logic        st;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_data;
    logic [2:0]  exp_ctrl;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic st, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd);
    req_valid    = 1'b1;
    req_is_store = st;
    req_op       = op;
    req_addr     = addr;
    req_wdata    = wd;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    issue(v.st, v.op, v.addr, v.wdata);
    check($sformatf("v%0d_req_ready", idx), req_ready, 1'b1);
    step();
    req_valid    = 1'b0;
    avm_readdata = v.rdata;
    check($sformatf("v%0d_read", idx), avm_read, !v.st);
    check($sformatf("v%0d_write", idx), avm_write, v.st);
    check($sformatf("v%0d_addr", idx), avm_address, v.exp_addr);
    check($sformatf("v%0d_be", idx), avm_byteenable, v.exp_be);
    check($sformatf("v%0d_rsp_early", idx), rsp_valid, 1'b0);
    if (v.st) check($sformatf("v%0d_wd", idx), avm_writedata, v.exp_wd);
    step();
    check($sformatf("v%0d_strobe_off", idx), avm_read | avm_write, 1'b0);
    if (v.st) begin
      check($sformatf("v%0d_no_rsp", idx), rsp_valid, 1'b0);
      check($sformatf("v%0d_ready_back", idx), req_ready, 1'b1);
    end else begin
      check($sformatf("v%0d_rsp_valid", idx), rsp_valid, 1'b1);
      check($sformatf("v%0d_data", idx), rsp_data, v.exp_data);
      check($sformatf("v%0d_ctrl", idx), rsp_ctrl, v.exp_ctrl);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check($sformatf("v%0d_rsp_done", idx), rsp_valid, 1'b0);
      check($sformatf("v%0d_idle", idx), req_ready, 1'b1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //          st    op      addr          wdata         rdata         exp_addr      be       exp_wd        exp_data      ctrl
    vecs[0]  = '{1'b0, 3'b000, 32'h0000_1001, 32'h0,        32'h4433_2211, 32'h0000_1000, 4'b1111, 32'h0,        32'h0044_3322, 3'b000};
    vecs[1]  = '{1'b0, 3'b001, 32'h0000_1003, 32'h0,        32'h4433_2211, 32'h0000_1000, 4'b1111, 32'h0,        32'h0000_0044, 3'b001};
    vecs[2]  = '{1'b0, 3'b010, 32'h0000_1002, 32'h0,        32'h4433_2211, 32'h0000_1000, 4'b1111, 32'h0,        32'h0000_4433, 3'b010};
    vecs[3]  = '{1'b0, 3'b011, 32'h0000_1000, 32'h0,        32'h4433_2211, 32'h0000_1000, 4'b1111, 32'h0,        32'h4433_2211, 3'b011};
    vecs[4]  = '{1'b0, 3'b101, 32'h0000_1004, 32'h0,        32'h4433_2211, 32'h0000_1004, 4'b1111, 32'h0,        32'h4433_2211, 3'b101};
    vecs[5]  = '{1'b0, 3'b110, 32'h0000_1001, 32'hAABB_CCDD, 32'h4433_2211, 32'h0000_1000, 4'b1111, 32'h0,        32'h2211_CCDD, 3'b101};
    vecs[6]  = '{1'b0, 3'b111, 32'h0000_1001, 32'hAABB_CCDD, 32'h4433_2211, 32'h0000_1000, 4'b1111, 32'h0,        32'hAA44_3322, 3'b101};
    vecs[7]  = '{1'b0, 3'b110, 32'h0000_1003, 32'hAABB_CCDD, 32'h4433_2211, 32'h0000_1000, 4'b1111, 32'h0,        32'h4433_2211, 3'b101};
    vecs[8]  = '{1'b0, 3'b110, 32'h0000_1000, 32'hAABB_CCDD, 32'h4433_2211, 32'h0000_1000, 4'b1111, 32'h0,        32'h11BB_CCDD, 3'b101};
    vecs[9]  = '{1'b0, 3'b111, 32'h0000_1000, 32'hAABB_CCDD, 32'h4433_2211, 32'h0000_1000, 4'b1111, 32'h0,        32'h4433_2211, 3'b101};
    vecs[10] = '{1'b0, 3'b111, 32'h0000_1003, 32'hAABB_CCDD, 32'h4433_2211, 32'h0000_1000, 4'b1111, 32'h0,        32'hAABB_CC44, 3'b101};
    vecs[11] = '{1'b0, 3'b100, 32'h0000_1008, 32'h0,        32'h8765_4321, 32'h0000_1008, 4'b1111, 32'h0,        32'h8765_4321, 3'b101};
    vecs[12] = '{1'b1, 3'b000, 32'h0000_2001, 32'h1234_5678, 32'h0,        32'h0000_2000, 4'b0010, 32'h7878_7878, 32'h0,        3'b000};
    vecs[13] = '{1'b1, 3'b010, 32'h0000_2002, 32'h0000_BEEF, 32'h0,        32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 32'h0,        3'b000};
    vecs[14] = '{1'b1, 3'b010, 32'h0000_2000, 32'h1111_2222, 32'h0,        32'h0000_2000, 4'b0011, 32'h2222_2222, 32'h0,        3'b000};
    vecs[15] = '{1'b1, 3'b101, 32'h0000_2004, 32'hDEAD_BEEF, 32'h0,        32'h0000_2004, 4'b1111, 32'hDEAD_BEEF, 32'h0,        3'b000};
    vecs[16] = '{1'b1, 3'b011, 32'h0000_2008, 32'hCAFE_0001, 32'h0,        32'h0000_2008, 4'b1111, 32'hCAFE_0001, 32'h0,        3'b000};

    reset           = 1'b0;
    req_valid       = 1'b0;
    req_is_store    = 1'b0;
    req_op          = 3'b000;
    req_addr        = '0;
    req_wdata       = '0;
    rsp_ready       = 1'b0;
    avm_waitrequest = 1'b0;
    avm_readdata    = '0;

    #12;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_read", avm_read, 1'b0);
    check("rst_write", avm_write, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_addr_err", addr_err, 1'b0);
    check("rst_be", avm_byteenable, 4'b0000);
    reset = 1'b1;
    step();

    for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

    // SB with three wait cycles: write strobe held for four cycles.
    avm_waitrequest = 1'b1;
    issue(1'b1, 3'b000, 32'h0000_2003, 32'h0000_00EF);
    step();
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("sbw_write_%0d", k), avm_write, 1'b1);
      check($sformatf("sbw_be_%0d", k), avm_byteenable, 4'b1000);
      check($sformatf("sbw_wd_%0d", k), avm_writedata, 32'hEFEF_EFEF);
      check($sformatf("sbw_addr_%0d", k), avm_address, 32'h0000_2000);
      check($sformatf("sbw_ready_%0d", k), req_ready, 1'b0);
      step();
    end
    avm_waitrequest = 1'b0;
    check("sbw_write_3", avm_write, 1'b1);
    step();
    check("sbw_write_off", avm_write, 1'b0);
    check("sbw_no_rsp", rsp_valid, 1'b0);
    check("sbw_ready_back", req_ready, 1'b1);

    // Misaligned LW rejected; the next request is taken the following cycle.
    issue(1'b0, 3'b101, 32'h0000_3002, 32'h0);
    step();
    check("mis_addr_err", addr_err, 1'b1);
    check("mis_no_read", avm_read, 1'b0);
    check("mis_ready", req_ready, 1'b1);
    issue(1'b0, 3'b101, 32'h0000_3000, 32'h0);
    step();
    req_valid    = 1'b0;
    avm_readdata = 32'hCAFE_F00D;
    check("mis_err_pulse", addr_err, 1'b0);
    check("mis_next_read", avm_read, 1'b1);
    check("mis_next_addr", avm_address, 32'h0000_3000);
    step();
    check("mis_next_rsp", rsp_valid, 1'b1);
    check("mis_next_data", rsp_data, 32'hCAFE_F00D);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Response back-pressure: data held, no new requests taken.
    issue(1'b0, 3'b010, 32'h0000_4002, 32'h0);
    step();
    req_valid    = 1'b0;
    avm_readdata = 32'h8001_7FFF;
    step();
    avm_readdata = 32'h0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_valid_%0d", k), rsp_valid, 1'b1);
      check($sformatf("bp_data_%0d", k), rsp_data, 32'h0000_8001);
      check($sformatf("bp_ctrl_%0d", k), rsp_ctrl, 3'b010);
      check($sformatf("bp_ready_%0d", k), req_ready, 1'b0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("bp_done", rsp_valid, 1'b0);
    check("bp_idle", req_ready, 1'b1);

    // Asynchronous reset while a read is stalled on the bus.
    avm_waitrequest = 1'b1;
    issue(1'b0, 3'b101, 32'h0000_5000, 32'h0);
    step();
    req_valid = 1'b0;
    check("ar_read_before", avm_read, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("ar_read_drop", avm_read, 1'b0);
    check("ar_write_drop", avm_write, 1'b0);
    check("ar_rsp_drop", rsp_valid, 1'b0);
    check("ar_ready", req_ready, 1'b1);
    #2 reset = 1'b1;
    avm_waitrequest = 1'b0;
    avm_readdata    = 32'h1234_5678;
    step();
    check("ar_no_rsp_1", rsp_valid, 1'b0);
    check("ar_no_read", avm_read, 1'b0);
    check("ar_ready_1", req_ready, 1'b1);
    step();
    check("ar_no_rsp_2", rsp_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
